// File: rtl/cdr_pkg.sv
// Shared types and helpers for the bang-bang CDR loop.
package cdr_pkg;

    typedef enum logic [1:0] {
        PD_NONE  = 2'b00,
        PD_EARLY = 2'b01,
        PD_LATE  = 2'b10
    } pd_dec_e;

    // Signed vote accumulator width: holds up to +/-(vote_len-1) partial votes.
    function automatic int unsigned vote_w(int unsigned vote_len);
        return $clog2(vote_len) + 1;
    endfunction

    function automatic int sat_add(int a, int b, int lim);
        int s;
        s = a + b;
        if (s > lim) begin
            return lim;
        end
        if (s < -lim) begin
            return -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/cdr_bbpd_loop_if.sv
// Sample inputs, loop controls and loop outputs of the CDR block.
interface cdr_bbpd_loop_if #(
    parameter int unsigned PHASE_W = 5,
    parameter int unsigned FREQ_W  = 8
);
    logic               Dn;
    logic               Pn;
    logic               Dn_1;
    logic [1:0]         gainsel;
    logic               freq_en;
    logic [1:0]         ki_sel;
    logic [PHASE_W-1:0] phase_shift;
    logic [FREQ_W-1:0]  freq_acc;
    logic               locked;
    logic [1:0]         pd_decision;

    modport master (
        output Dn, Pn, Dn_1, gainsel, freq_en, ki_sel,
        input  phase_shift, freq_acc, locked, pd_decision
    );

    modport slave (
        input  Dn, Pn, Dn_1, gainsel, freq_en, ki_sel,
        output phase_shift, freq_acc, locked, pd_decision
    );
endinterface

// File: rtl/cdr_bbpd.sv
// Alexander phase detector: combinational vote plus registered decision.
module cdr_bbpd
    import cdr_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              dn_i,
    input  logic              pn_i,
    input  logic              dn1_i,
    output logic signed [1:0] vote_o,
    output pd_dec_e           pd_decision_o
);
    pd_dec_e dec_d, dec_q;

    always_comb begin
        dec_d  = PD_NONE;
        vote_o = 2'sd0;
        if (dn_i != dn1_i) begin
            if (pn_i == dn1_i) begin
                dec_d  = PD_EARLY;
                vote_o = -2'sd1;
            end else begin
                dec_d  = PD_LATE;
                vote_o = 2'sd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dec_q <= PD_NONE;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign pd_decision_o = dec_q;
endmodule

// File: rtl/cdr_bbpd_loop.sv
// Bang-bang CDR loop: windowed vote, PI loop filter, phase accumulator, lock detect.
module cdr_bbpd_loop
    import cdr_pkg::*;
#(
    parameter int unsigned PHASE_W  = 5,
    parameter int unsigned VOTE_LEN = 8,
    parameter int unsigned FREQ_W   = 8,
    parameter int unsigned LOCK_CNT = 16
) (
    input logic            BitCLK,
    input logic            Reset,
    cdr_bbpd_loop_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(VOTE_LEN);
    localparam int unsigned VW       = vote_w(VOTE_LEN);
    localparam int unsigned NW       = VW + 1;
    localparam int unsigned LCW      = $clog2(LOCK_CNT + 1);
    localparam int          FREQ_MAX = (2 ** (FREQ_W - 1)) - 1;

    logic signed [1:0]        vote;
    pd_dec_e                  pd_dec;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [VW-1:0]     acc_q, acc_d;
    logic signed [NW-1:0]     net;
    logic [NW-1:0]            net_abs;
    logic                     win_end;
    logic                     quiet;
    logic [PHASE_W-1:0]       phase_q, phase_d, prop, step;
    logic signed [FREQ_W-1:0] freq_q, freq_d, freq_step;
    logic [LCW-1:0]           lock_cnt_q, lock_cnt_d;
    logic                     locked_q, locked_d;
    int unsigned              shamt;
    int                       sgn;

    cdr_bbpd u_bbpd (
        .clk_i         (BitCLK),
        .rst_ni        (Reset),
        .dn_i          (bus.Dn),
        .pn_i          (bus.Pn),
        .dn1_i         (bus.Dn_1),
        .vote_o        (vote),
        .pd_decision_o (pd_dec)
    );

    always_comb begin
        win_end = (cnt_q == CNT_W'(VOTE_LEN - 1));
        cnt_d   = cnt_q + 1'b1;
        // The window-closing sample is folded into net directly, never into acc.
        net     = NW'(acc_q) + NW'(vote);
        acc_d   = win_end ? '0 : acc_q + VW'(vote);
        net_abs = (net < 0) ? $unsigned(-net) : $unsigned(net);
        quiet   = (net_abs <= NW'(VOTE_LEN / 4));

        step = PHASE_W'(1) << bus.gainsel;
        if (net > 0) begin
            prop = step;
            sgn  = 1;
        end else if (net < 0) begin
            prop = '0 - step;
            sgn  = -1;
        end else begin
            prop = '0;
            sgn  = 0;
        end

        shamt     = FREQ_W - 2 - int'(bus.ki_sel);
        freq_step = bus.freq_en ? (freq_q >>> shamt) : '0;

        phase_d    = phase_q;
        freq_d     = bus.freq_en ? freq_q : '0;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;

        if (win_end) begin
            phase_d = phase_q + prop + PHASE_W'(freq_step);
            if (bus.freq_en) begin
                freq_d = FREQ_W'(sat_add(int'(freq_q), sgn, FREQ_MAX));
            end
            if (!quiet) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LCW'(LOCK_CNT)) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
            locked_d = (lock_cnt_d == LCW'(LOCK_CNT));
        end
    end

    always_ff @(posedge BitCLK) begin
        if (!Reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            freq_q     <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            freq_q     <= freq_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.phase_shift = phase_q;
    assign bus.freq_acc    = freq_q;
    assign bus.locked      = locked_q;
    assign bus.pd_decision = pd_dec;
endmodule

// File: tb/tb_cdr_bbpd_loop.sv
// Directed bench for cdr_bbpd_loop with hand-computed expectations.
module tb_cdr_bbpd_loop;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    cdr_bbpd_loop_if #(.PHASE_W(5), .FREQ_W(8)) bus ();

    cdr_bbpd_loop #(
        .PHASE_W  (5),
        .VOTE_LEN (8),
        .FREQ_W   (8),
        .LOCK_CNT (16)
    ) dut (
        .BitCLK (clk),
        .Reset  (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic drive(input logic d1, input logic d, input logic p);
        bus.Dn_1 = d1;
        bus.Dn   = d;
        bus.Pn   = p;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        step(n);
        rst_n = 1'b1;
    endtask

    task automatic late();  drive(1'b0, 1'b1, 1'b1); endtask
    task automatic early(); drive(1'b0, 1'b1, 1'b0); endtask

    initial begin
        bus.gainsel = 2'd2;
        bus.freq_en = 1'b0;
        bus.ki_sel  = 2'd0;
        drive(1'b0, 1'b0, 1'b0);

        // Reset with random samples
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom));
            step(1);
        end
        check("rst_phase",  32'(bus.phase_shift), 0);
        check("rst_freq",   32'(bus.freq_acc), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_pd",     32'(bus.pd_decision), 0);

        // Constant LATE, gainsel=2
        rst_n = 1'b1;
        late();
        step(1);
        check("pd_late", 32'(bus.pd_decision), 2);
        step(6);
        check("late_hold7", 32'(bus.phase_shift), 0);
        step(1);
        check("late_w1", 32'(bus.phase_shift), 4);
        step(6 * 8);
        check("late_w7", 32'(bus.phase_shift), 28);
        step(8);
        check("late_wrap", 32'(bus.phase_shift), 0);
        check("late_freq0", 32'(bus.freq_acc), 0);
        check("late_unlocked", 32'(bus.locked), 0);

        // Constant EARLY, gainsel=0: downward wrap
        do_reset(1);
        bus.gainsel = 2'd0;
        early();
        step(1);
        check("pd_early", 32'(bus.pd_decision), 1);
        step(7);
        check("early_wrap", 32'(bus.phase_shift), 31);

        // Balanced windows drive lock
        do_reset(1);
        bus.gainsel = 2'd1;
        for (int w = 0; w < 15; w++) begin
            early(); step(4);
            late();  step(4);
        end
        check("lock_w15", 32'(bus.locked), 0);
        check("lock_phase_hold", 32'(bus.phase_shift), 0);
        early(); step(4);
        late();  step(4);
        check("lock_w16", 32'(bus.locked), 1);
        drive(1'b1, 1'b1, 1'b0);
        step(1);
        check("pd_none", 32'(bus.pd_decision), 0);
        step(7);
        check("lock_quiet_notrans", 32'(bus.locked), 1);
        late();
        step(7);
        check("lock_mid_window", 32'(bus.locked), 1);
        step(1);
        check("lock_lost", 32'(bus.locked), 0);
        check("lock_lost_phase", 32'(bus.phase_shift), 2);

        // Integral path, ki_sel=0, gainsel=0
        do_reset(1);
        bus.gainsel = 2'd0;
        bus.freq_en = 1'b1;
        late();
        step(8);
        check("freq_w1", 32'(bus.freq_acc), 1);
        check("freq_w1_phase", 32'(bus.phase_shift), 1);
        step(63 * 8);
        check("freq_w64", 32'(bus.freq_acc), 64);
        check("freq_w64_phase", 32'(bus.phase_shift), 0);
        step(8);
        check("freq_w65_phase", 32'(bus.phase_shift), 2);
        step(62 * 8);
        check("freq_w127", 32'(bus.freq_acc), 127);
        check("freq_w127_phase", 32'(bus.phase_shift), 30);
        step(8);
        check("freq_sat", 32'(bus.freq_acc), 127);
        check("freq_w128_phase", 32'(bus.phase_shift), 0);
        bus.freq_en = 1'b0;
        step(1);
        check("freq_force0", 32'(bus.freq_acc), 0);

        // Mid-window reset discards partial votes
        do_reset(1);
        late();
        step(5);
        do_reset(1);
        early();
        step(3);
        check("midrst_3", 32'(bus.phase_shift), 0);
        step(4);
        check("midrst_7", 32'(bus.phase_shift), 0);
        step(1);
        check("midrst_w1", 32'(bus.phase_shift), 31);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cdr_bbpd_loop.md
Name: cdr_bbpd_loop

Overview:
- Parametrised bang-bang CDR loop for the RX path. Successor to the fixed single-step phase-update CDR.
- Takes Alexander-style samples (Dn, Pn, Dn_1) each bit clock and majority-votes early/late decisions over a window.
- Drives the phase-interpolator code through a proportional path plus an optional integral (frequency-tracking) path, with a lock detector.

Parameters:
- PHASE_W, 5: phase_shift width; code wraps modulo 2^PHASE_W.
- VOTE_LEN, 8: decisions per vote window (power of 2, at least 4).
- FREQ_W, 8: signed integrator width (at least 6).
- LOCK_CNT, 16: consecutive quiet windows required to assert locked.

Ports:
- BitCLK  in  1  bit clock; all logic on posedge.
- Reset  in  1  synchronous, active-low; Reset==0 resets on the next BitCLK edge.
- Dn  in  1  current data sample.
- Pn  in  1  edge sample between Dn_1 and Dn.
- Dn_1  in  1  previous data sample.
- gainsel  in  2  proportional step = 1<<gainsel (1/2/4/8).
- freq_en  in  1  enables the integral path.
- ki_sel  in  2  integral gain select.
- phase_shift  out  PHASE_W  PI phase code.
- freq_acc  out  FREQ_W  signed integrator value.
- locked  out  1  lock indication.
- pd_decision  out  2  registered PD result: 00 none, 01 early, 10 late; 11 never driven.

Behaviour:
- Reset (Reset==0 at an edge): phase_shift=0, freq_acc=0, locked=0, pd_decision=00. Window counter, vote accumulator and lock counter are cleared. A partial window is discarded. The first window starts on the first edge with Reset==1.
- PD, per cycle:
  - No transition (Dn==Dn_1): NONE.
  - Pn==Dn_1 with a transition: EARLY, vote -1.
  - Pn==Dn with a transition: LATE, vote +1.
  - pd_decision is registered, 1-cycle latency.
- Window counter runs 0..VOTE_LEN-1, wraps. The signed vote accumulator is clog2(VOTE_LEN)+1 bits wide.
- At the edge where the counter equals VOTE_LEN-1:
  - net = accumulator + current vote.
  - The accumulator clears for the next window.
- Proportional step: +(1<<gainsel) if net>0, -(1<<gainsel) if net<0, 0 if net==0. gainsel is sampled at the window-end edge.
- Integral step: freq_step = old freq_acc >>> (FREQ_W-2-ki_sel), arithmetic shift. freq_step is 0 when freq_en==0.
- Phase update at the window-end edge: phase_shift <= phase_shift + prop + freq_step, modulo 2^PHASE_W. Wrap is silent in both directions. The change is visible 1 cycle after the last sample of the window.
- Integrator update at the same edge:
  - freq_acc += sign(net), saturating at ±(2^(FREQ_W-1)-1).
  - net==0 holds the value.
  - freq_en==0 forces freq_acc to 0 at every edge.
- Lock detection:
  - A window is quiet if |net| <= VOTE_LEN/4.
  - A quiet window increments the lock counter, saturating at LOCK_CNT.
  - A non-quiet window clears the counter.
  - locked==1 iff the counter equals LOCK_CNT. It is registered, so it rises and falls 1 cycle after the deciding window edge.
- Between window ends, phase_shift, freq_acc and locked hold.

Decomposition:
- Package cdr_pkg:
  - pd_dec_e enum (PD_NONE, PD_EARLY, PD_LATE) and its encodings.
  - Vote-width localparam function.
  - Saturating signed add function.
- Sub-module cdr_bbpd: PD decode plus the registered pd_decision output.
- cdr_bbpd_loop contains the window counter, vote accumulator, loop filter, phase accumulator and lock detector.

Test Plan:
- Reset held low 3 cycles with random Dn/Pn/Dn_1 -> all outputs 0. No phase change until 8 decisions after release.
- gainsel=2, freq_en=0, constant LATE (Dn_1=0, Dn=1, Pn=1) -> phase_shift 0→4 one cycle after 8th sample. After 8 windows it wraps 28→0.
- gainsel=0, constant EARLY (Dn_1=0, Dn=1, Pn=0) from phase 0 -> phase_shift=31 after first window (downward wrap).
- Alternating 4 EARLY/4 LATE per window, or no transitions -> phase holds; locked=1 one cycle after 16th window. Then one all-LATE window -> locked=0 one cycle after that window edge.
- freq_en=1, ki_sel=0, gainsel=0, constant LATE -> freq_acc +1 per window; at freq_acc=64, phase steps by 2 per window. freq_acc saturates and holds at 127.
- Reset pulsed low after 5 LATE decisions mid-window, then 8 EARLY -> net=-8, phase_shift=31 (gainsel=0). The partial votes have no effect.
